// File: rtl/wave_dac_spi.sv
// Waveform output stage: signed samples -> offset-binary codes -> FIFO -> SPI mode-0 DAC frames.
// Each frame is a command prefix followed by the code, shifted MSB-first.
module wave_dac_spi #(
  parameter int                  DAC_BITS   = 12,
  parameter int                  CMD_BITS   = 4,
  parameter logic [CMD_BITS-1:0] CMD        = 4'b0011,
  parameter int                  DIV        = 2,
  parameter int                  FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         sample_valid,
  input  logic signed [15:0]           wave_in,
  input  logic                         ovf_clr,
  output logic                         cs_n,
  output logic                         sclk,
  output logic                         mosi,
  output logic                         busy,
  output logic                         ovf,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);
  localparam int FB = CMD_BITS + DAC_BITS;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(FB + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_e;

  state_e              state_q, state_d;
  logic [FB-1:0]       shreg_q, shreg_d;
  logic [DW-1:0]       div_q, div_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic                sclk_q, sclk_d;
  logic                ovf_q, ovf_d;
  logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]       lvl_q, lvl_d;
  logic [DAC_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [15:0]         flip;
  logic [DAC_BITS-1:0] code;
  logic                push_req, full, pop, push, drop;

  // Flipping the sign bit turns two's complement into offset binary; keep the top bits.
  assign flip     = {~wave_in[15], wave_in[14:0]};
  assign code     = DAC_BITS'(flip >> (16 - DAC_BITS));
  assign push_req = en & sample_valid;
  assign full     = (lvl_q == LW'(FIFO_DEPTH));
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (push) wr_d = wr_q + AW'(1);
    if (pop)  rd_d = rd_q + AW'(1);
    case ({push, pop})
      2'b10:   lvl_d = lvl_q + LW'(1);
      2'b01:   lvl_d = lvl_q - LW'(1);
      default: ;
    endcase
    ovf_d = drop | (ovf_q & ~ovf_clr);
  end

  // When full, wr_q == rd_q: the pop reads the old entry before the same-edge write lands.
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      ovf_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      lvl_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      ovf_q   <= ovf_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      lvl_q   <= lvl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (lvl_q != '0) begin
        pop     = 1'b1;
        shreg_d = {CMD, mem_q[rd_q]};
        div_d   = '0;
        bit_d   = '0;
        sclk_d  = 1'b0;
        state_d = SHIFT;
      end
      SHIFT: if (div_q == DW'(DIV - 1)) begin
        div_d  = '0;
        sclk_d = ~sclk_q;
        // Data advances only on the falling edge so mosi is stable at every rise.
        if (sclk_q) begin
          shreg_d = shreg_q << 1;
          bit_d   = bit_q + BW'(1);
          if (bit_q == BW'(FB - 1)) state_d = HOLD;
        end
      end else begin
        div_d = div_q + DW'(1);
      end
      HOLD: if (div_q == DW'(DIV - 1)) state_d = IDLE;
            else div_d = div_q + DW'(1);
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cs_n = 1'b1;
    mosi = 1'b0;
    busy = 1'b0;
    case (state_q)
      SHIFT: begin
        cs_n = 1'b0;
        mosi = shreg_q[FB-1];
        busy = 1'b1;
      end
      HOLD:    busy = 1'b1;
      default: ;
    endcase
  end

  assign sclk       = sclk_q;
  assign ovf        = ovf_q;
  assign fifo_level = lvl_q;
endmodule
